// File: rtl/reg_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_arbiter_if
// Brief    : Result/issue/write-back bundle between execution units and the
//            register-file write-back arbiter.
// Revision : 1.0
// ============================================================================
interface reg_wb_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  ALU_VALID;
    logic                  ALU_READY;
    logic [4:0]            ALU_RD;
    logic [DATA_WIDTH-1:0] ALU_DATA;
    logic                  MEM_VALID;
    logic                  MEM_READY;
    logic [4:0]            MEM_RD;
    logic [DATA_WIDTH-1:0] MEM_DATA;
    logic                  ISSUE_VALID;
    logic [4:0]            ISSUE_RD;
    logic [31:0]           BUSY_MASK;
    logic                  WRITE_ENABLE;
    logic [4:0]            WRITE_ADDRESS;
    logic [DATA_WIDTH-1:0] WRITE_DATA;
    logic [c_CNT_W-1:0]    FIFO_COUNT;

    modport master (
        output ALU_VALID, ALU_RD, ALU_DATA,
        output MEM_VALID, MEM_RD, MEM_DATA,
        output ISSUE_VALID, ISSUE_RD,
        input  ALU_READY, MEM_READY, BUSY_MASK,
        input  WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, FIFO_COUNT
    );

    modport slave (
        input  ALU_VALID, ALU_RD, ALU_DATA,
        input  MEM_VALID, MEM_RD, MEM_DATA,
        input  ISSUE_VALID, ISSUE_RD,
        output ALU_READY, MEM_READY, BUSY_MASK,
        output WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, FIFO_COUNT
    );
endinterface
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_wb_arbiter
// Brief    : Single-port register write-back arbiter: ALU results win, long-
//            latency results queue in a FIFO, plus a pending-write scoreboard.
// Revision : 1.0
// ============================================================================
module reg_wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic          CLOCK,
    input  wire logic          RESET,
    reg_wb_arbiter_if.slave    bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

    logic [4:0]            r_q_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_q_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [31:0]           r_busy;
    logic                  r_we;
    logic [4:0]            r_wa;
    logic [DATA_WIDTH-1:0] r_wd;

    logic                  w_ready;
    logic                  w_alu_acc;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_wr_en;
    logic [4:0]            w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [31:0]           w_set;
    logic [31:0]           w_clr;
    logic [31:0]           w_busy_next;

    // A full queue stalls the ALU too, so the head is guaranteed a slot.
    always_comb begin
        w_ready    = !RESET && (r_count != c_FULL);
        w_alu_acc  = bus.ALU_VALID && w_ready;
        w_push     = bus.MEM_VALID && w_ready && (bus.MEM_RD != 5'd0);
        w_pop      = !w_alu_acc && (r_count != '0);
        w_sel_rd   = 5'd0;
        w_sel_data = '0;
        if (w_alu_acc) begin
            w_sel_rd   = bus.ALU_RD;
            w_sel_data = bus.ALU_DATA;
        end else if (w_pop) begin
            w_sel_rd   = r_q_rd[r_rd_ptr];
            w_sel_data = r_q_data[r_rd_ptr];
        end
        w_wr_en = (w_alu_acc || w_pop) && (w_sel_rd != 5'd0);
    end

    always_comb begin
        w_set       = '0;
        w_clr       = '0;
        if (bus.ISSUE_VALID && (bus.ISSUE_RD != 5'd0)) begin
            w_set = 32'd1 << bus.ISSUE_RD;
        end
        if (w_wr_en) begin
            w_clr = 32'd1 << w_sel_rd;
        end
        // Set is applied after clear so a same-edge reissue keeps the bit.
        w_busy_next = ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end

    always_ff @(posedge CLOCK) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr]   <= bus.MEM_RD;
            r_q_data[r_wr_ptr] <= bus.MEM_DATA;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_busy   <= '0;
            r_we     <= 1'b0;
            r_wa     <= 5'd0;
            r_wd     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_busy <= w_busy_next;
            r_we   <= w_wr_en;
            if (w_wr_en) begin
                r_wa <= w_sel_rd;
                r_wd <= w_sel_data;
            end
        end
    end

    assign bus.ALU_READY     = w_ready;
    assign bus.MEM_READY     = w_ready;
    assign bus.BUSY_MASK     = r_busy;
    assign bus.WRITE_ENABLE  = r_we;
    assign bus.WRITE_ADDRESS = r_wa;
    assign bus.WRITE_DATA    = r_wd;
    assign bus.FIFO_COUNT    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_wb_arbiter
// Brief    : Self-checking bench for reg_wb_arbiter: queue-based reference
//            model plus directed scenarios with literal expectations.
// Revision : 1.0
// ============================================================================
module tb_reg_wb_arbiter;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]    rd;
        logic [DW-1:0] d;
    } ent_t;

    logic CLOCK = 1'b0;
    logic RESET;
    int   total = 0;
    int   bad   = 0;

    ent_t          q[$];
    logic [31:0]   m_busy;
    logic          m_we;
    logic [4:0]    m_wa;
    logic [DW-1:0] m_wd;

    always #5 CLOCK = ~CLOCK;

    reg_wb_arbiter_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    reg_wb_arbiter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit av, input int ard, input logic [DW-1:0] ad,
                         input bit mv, input int mrd, input logic [DW-1:0] md,
                         input bit iv, input int ird);
        bus.ALU_VALID   = av;
        bus.ALU_RD      = 5'(ard);
        bus.ALU_DATA    = ad;
        bus.MEM_VALID   = mv;
        bus.MEM_RD      = 5'(mrd);
        bus.MEM_DATA    = md;
        bus.ISSUE_VALID = iv;
        bus.ISSUE_RD    = 5'(ird);
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, '0, 0, 0);
    endtask

    // One clock: check readies, advance the model, then compare registered outputs.
    task automatic step();
        bit   rdy;
        bit   have;
        ent_t src;
        ent_t nw;
        #2;
        rdy = !RESET && (q.size() != DEPTH);
        chk("alu_ready", 64'(bus.ALU_READY), 64'(rdy));
        chk("mem_ready", 64'(bus.MEM_READY), 64'(rdy));
        if (RESET) begin
            q.delete();
            m_busy = '0;
            m_we   = 1'b0;
            m_wa   = '0;
            m_wd   = '0;
        end else begin
            have   = 0;
            src.rd = '0;
            src.d  = '0;
            if (bus.ALU_VALID && rdy) begin
                src.rd = bus.ALU_RD;
                src.d  = bus.ALU_DATA;
                have   = 1;
            end else if (q.size() > 0) begin
                src  = q.pop_front();
                have = 1;
            end
            if (bus.MEM_VALID && rdy && bus.MEM_RD != 5'd0) begin
                nw.rd = bus.MEM_RD;
                nw.d  = bus.MEM_DATA;
                q.push_back(nw);
            end
            m_we = have && (src.rd != 5'd0);
            if (m_we) begin
                m_wa         = src.rd;
                m_wd         = src.d;
                m_busy[src.rd] = 1'b0;
            end
            if (bus.ISSUE_VALID && bus.ISSUE_RD != 5'd0) m_busy[bus.ISSUE_RD] = 1'b1;
        end
        @(posedge CLOCK);
        #1;
        chk("write_enable",  64'(bus.WRITE_ENABLE),  64'(m_we));
        chk("write_address", 64'(bus.WRITE_ADDRESS), 64'(m_wa));
        chk("write_data",    64'(bus.WRITE_DATA),    64'(m_wd));
        chk("busy_mask",     64'(bus.BUSY_MASK),     64'(m_busy));
        chk("fifo_count",    64'(bus.FIFO_COUNT),    64'(q.size()));
    endtask

    initial begin
        RESET = 1'b1;
        idle();
        step();
        step();
        chk("rst_we",    64'(bus.WRITE_ENABLE), 64'd0);
        chk("rst_count", 64'(bus.FIFO_COUNT),   64'd0);
        RESET = 1'b0;

        // Single ALU write, one-cycle latency.
        drive(1, 5, 64'hA5, 0, 0, '0, 0, 0);
        step();
        chk("alu_we",   64'(bus.WRITE_ENABLE),  64'd1);
        chk("alu_addr", 64'(bus.WRITE_ADDRESS), 64'd5);
        chk("alu_data", 64'(bus.WRITE_DATA),    64'hA5);
        idle();
        step();
        chk("alu_we_off", 64'(bus.WRITE_ENABLE), 64'd0);

        // ALU and MEM together: ALU first, queued MEM next.
        drive(1, 3, 64'h33, 1, 7, 64'h77, 0, 0);
        step();
        chk("both_addr1", 64'(bus.WRITE_ADDRESS), 64'd3);
        chk("both_cnt1",  64'(bus.FIFO_COUNT),    64'd1);
        idle();
        step();
        chk("both_addr2", 64'(bus.WRITE_ADDRESS), 64'd7);
        chk("both_data2", 64'(bus.WRITE_DATA),    64'h77);
        chk("both_cnt2",  64'(bus.FIFO_COUNT),    64'd0);

        // Fill the queue under continuous ALU traffic.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 10 + i, 64'(i), 1, i, 64'h100 + 64'(i), 0, 0);
            step();
        end
        chk("full_cnt", 64'(bus.FIFO_COUNT), 64'd4);
        drive(1, 20, 64'h20, 0, 0, '0, 0, 0);
        #1;
        chk("full_alu_ready", 64'(bus.ALU_READY), 64'd0);
        chk("full_mem_ready", 64'(bus.MEM_READY), 64'd0);
        step();
        chk("full_head_addr", 64'(bus.WRITE_ADDRESS), 64'd1);
        chk("full_head_data", 64'(bus.WRITE_DATA),    64'h101);
        chk("full_cnt3",      64'(bus.FIFO_COUNT),    64'd3);
        #1;
        chk("resume_alu_ready", 64'(bus.ALU_READY), 64'd1);
        step();
        chk("resume_addr", 64'(bus.WRITE_ADDRESS), 64'd20);
        idle();
        repeat (4) step();

        // Scoreboard set/clear and set-wins.
        drive(0, 0, '0, 0, 0, '0, 1, 9);
        step();
        chk("busy9_set", 64'(bus.BUSY_MASK[9]), 64'd1);
        idle();
        step();
        chk("busy9_hold", 64'(bus.BUSY_MASK[9]), 64'd1);
        drive(1, 9, 64'h99, 0, 0, '0, 0, 0);
        step();
        chk("busy9_clr", 64'(bus.BUSY_MASK[9]), 64'd0);
        drive(0, 0, '0, 0, 0, '0, 1, 9);
        step();
        drive(1, 9, 64'h98, 0, 0, '0, 1, 9);
        step();
        chk("busy9_setwins", 64'(bus.BUSY_MASK[9]), 64'd1);
        drive(1, 9, 64'h97, 0, 0, '0, 0, 0);
        step();

        // rd=0 results are accepted but never written.
        drive(1, 0, 64'hFF, 0, 0, '0, 1, 0);
        #1;
        chk("rd0_ready", 64'(bus.ALU_READY), 64'd1);
        step();
        chk("rd0_we",    64'(bus.WRITE_ENABLE), 64'd0);
        chk("rd0_busy0", 64'(bus.BUSY_MASK[0]), 64'd0);

        // Reset discards queued results.
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, '0, 1, 20 + i, 64'(i), 1, 12);
            step();
        end
        chk("prerst_cnt",    64'(bus.FIFO_COUNT),    64'd3);
        chk("prerst_busy12", 64'(bus.BUSY_MASK[12]), 64'd1);
        RESET = 1'b1;
        idle();
        step();
        chk("rst2_we",   64'(bus.WRITE_ENABLE),  64'd0);
        chk("rst2_addr", 64'(bus.WRITE_ADDRESS), 64'd0);
        chk("rst2_data", 64'(bus.WRITE_DATA),    64'd0);
        chk("rst2_cnt",  64'(bus.FIFO_COUNT),    64'd0);
        chk("rst2_busy", 64'(bus.BUSY_MASK),     64'd0);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("postrst_we", 64'(bus.WRITE_ENABLE), 64'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            RESET = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 99) < 45, $urandom_range(0, 31), {$urandom, $urandom},
                  $urandom_range(0, 99) < 60, $urandom_range(0, 31), {$urandom, $urandom},
                  $urandom_range(0, 99) < 30, $urandom_range(0, 31));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 64, result width; FIFO_DEPTH, 4, long-latency result queue entries (power of 2, >=2).
REQ-002 CLOCK  in  1  single clock; all state updates on rising edge.
REQ-003 RESET  in  1  reset, synchronous, active-high.
REQ-004 ALU_VALID  in  1  single-cycle result offered.
REQ-005 ALU_READY  out  1  ALU result accepted this cycle when high with ALU_VALID.
REQ-006 ALU_RD  in  5  ALU destination register.
REQ-007 ALU_DATA  in  DATA_WIDTH  ALU result.
REQ-008 MEM_VALID  in  1  long-latency (load/mul/div) result offered.
REQ-009 MEM_READY  out  1  MEM result accepted when high with MEM_VALID.
REQ-010 MEM_RD  in  5  MEM destination register.
REQ-011 MEM_DATA  in  DATA_WIDTH  MEM result.
REQ-012 ISSUE_VALID  in  1  instruction issued with pending destination.
REQ-013 ISSUE_RD  in  5  issued destination register.
REQ-014 BUSY_MASK  out  32  per-register pending-write scoreboard.
REQ-015 WRITE_ENABLE  out  1  register file write strobe.
REQ-016 WRITE_ADDRESS  out  5  register file write address.
REQ-017 WRITE_DATA  out  DATA_WIDTH  register file write data.
REQ-018 FIFO_COUNT  out  log2(FIFO_DEPTH)+1  MEM queue occupancy.

Function
REQ-019 MEM results SHALL enqueue into a FIFO_DEPTH-entry circular queue; MEM_READY = !RESET && FIFO_COUNT != FIFO_DEPTH.
REQ-020 ALU_READY SHALL equal !RESET && FIFO_COUNT != FIFO_DEPTH (full queue takes priority, bounds MEM starvation).
REQ-021 Each cycle exactly one write source SHALL be selected: accepted ALU result if ALU_VALID && ALU_READY, else queue head if queue non-empty, else none.
REQ-022 The selected result SHALL be registered onto WRITE_ENABLE/WRITE_ADDRESS/WRITE_DATA on the next edge: 1-cycle latency, at most one write per cycle.
REQ-023 No-source cycles SHALL drive WRITE_ENABLE=0; WRITE_ADDRESS/WRITE_DATA hold last value.
REQ-024 Results with rd=0 SHALL be accepted (handshake completes) but never produce WRITE_ENABLE; MEM rd=0 results SHALL not be enqueued.
REQ-025 Queue head SHALL be popped only in the cycle it is selected; simultaneous push and pop SHALL leave FIFO_COUNT unchanged.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; queue order SHALL be strict FIFO.
REQ-027 Empty queue with MEM_VALID and no ALU_VALID SHALL still incur enqueue-then-pop (no bypass): write appears 2 cycles after MEM accept.
REQ-028 BUSY_MASK[ISSUE_RD] SHALL set on the edge after ISSUE_VALID when ISSUE_RD != 0.
REQ-029 BUSY_MASK[n] SHALL clear on the same edge that asserts WRITE_ENABLE with WRITE_ADDRESS=n.
REQ-030 Same-edge set and clear of one bit SHALL resolve to set.
REQ-031 BUSY_MASK[0] SHALL be constant 0.

Reset
REQ-032 While RESET high at an edge: queue emptied, pointers 0, FIFO_COUNT=0, BUSY_MASK=0, WRITE_ENABLE=0, WRITE_ADDRESS=0, WRITE_DATA=0.
REQ-033 ALU_READY and MEM_READY SHALL be 0 while RESET high; in-flight queued results are discarded.
REQ-034 First handshake SHALL be possible in the first cycle after RESET deasserts.

Verification
REQ-035 ALU_VALID, ALU_RD=5, ALU_DATA=0xA5 for 1 cycle -> next cycle WRITE_ENABLE=1, WRITE_ADDRESS=5, WRITE_DATA=0xA5; following cycle WRITE_ENABLE=0.
REQ-036 ALU and MEM valid together (ALU rd=3, MEM rd=7) -> write rd=3 at T+1, rd=7 at T+2; FIFO_COUNT 1 then 0.
REQ-037 MEM pushes 4 results (rd 1..4) while ALU_VALID held continuously -> MEM_READY=0 and ALU_READY=0 at FIFO_COUNT=4; head rd=1 written next; ALU resumes next cycle.
REQ-038 ISSUE_VALID rd=9, later ALU write rd=9 -> BUSY_MASK[9] 1 until edge WRITE_ENABLE rises, then 0; concurrent ISSUE rd=9 at that edge -> stays 1.
REQ-039 ALU write rd=0 data=0xFF -> ALU_READY=1, WRITE_ENABLE stays 0, BUSY_MASK[0]=0.
REQ-040 RESET asserted with FIFO_COUNT=3 and BUSY_MASK nonzero -> next cycle all outputs 0; no queued write ever appears.
